// File: rtl/traffic_pkg.sv
// traffic_pkg: shared light codes, fault codes, monitor states and code helpers
package traffic_pkg;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] FLT_NONE     = 3'd0;
  localparam logic [2:0] FLT_INVALID  = 3'd1;
  localparam logic [2:0] FLT_CONFLICT = 3'd2;
  localparam logic [2:0] FLT_SEQ      = 3'd3;
  localparam logic [2:0] FLT_NONRED   = 3'd4;
  localparam logic [2:0] FLT_ALLRED   = 3'd5;
  typedef enum logic [1:0] {MON, FAULT, RECOVER} mon_state_t;
  function automatic logic is_onehot(input logic [2:0] c);
    return c == LIGHT_GREEN || c == LIGHT_YELLOW || c == LIGHT_RED;
  endfunction
  function automatic logic legal_step(input logic [2:0] p, input logic [2:0] c);
    return p == c || (p == LIGHT_GREEN && c == LIGHT_YELLOW) ||
           (p == LIGHT_YELLOW && c == LIGHT_RED) || (p == LIGHT_RED && c == LIGHT_GREEN);
  endfunction
endpackage

// File: rtl/road_checker.sv
// road_checker: per-road legality, sequence and non-red dwell checks
module road_checker
  import traffic_pkg::*;
#(
  parameter int MAX_NONRED = 12,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       en,
  input  logic       clr,
  input  logic [2:0] traffic,
  output logic       invalid,
  output logic       illegal,
  output logic       stuck
);
  logic [2:0] prev;
  logic [CNT_W-1:0] cnt;
  // previous code and saturating non-red dwell, tracked only while monitoring
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      prev <= LIGHT_RED;
      cnt  <= '0;
    end else if (clr) begin
      prev <= LIGHT_RED;
      cnt  <= '0;
    end else if (en) begin
      prev <= traffic;
      cnt  <= traffic == LIGHT_RED ? '0 : (tick && cnt != '1) ? cnt + 1'b1 : cnt;
    end
  assign invalid = !is_onehot(traffic);
  assign illegal = !legal_step(prev, traffic);
  assign stuck   = cnt > CNT_W'(MAX_NONRED);
endmodule

// File: rtl/signal_monitor.sv
// signal_monitor: conflict monitor and lamp driver with latched failsafe flashing red
module signal_monitor
  import traffic_pkg::*;
#(
  parameter int MAX_NONRED    = 12,
  parameter int MAX_ALLRED    = 6,
  parameter int FLASH_HALF    = 1,
  parameter int RECOVER_TICKS = 3,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [2:0] traffic_A,
  input  logic [2:0] traffic_B,
  input  logic       fault_clr,
  output logic [2:0] lamp_A,
  output logic [2:0] lamp_B,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash
);
  mon_state_t state, state_n;
  logic [2:0] lamp_a_n, lamp_b_n, code_n, viol;
  logic phase, phase_n, wrap;
  logic [CNT_W-1:0] phase_cnt, phase_cnt_n, rec_cnt, rec_cnt_n, allred_cnt, allred_cnt_n;
  logic inv_a, inv_b, ill_a, ill_b, stk_a, stk_b, in_mon, conflict, any_nonred, rec_done;
  assign in_mon     = state == MON;
  assign any_nonred = traffic_A != LIGHT_RED || traffic_B != LIGHT_RED;
  assign conflict   = traffic_A != LIGHT_RED && traffic_B != LIGHT_RED;
  assign rec_done   = state == RECOVER && rec_cnt == CNT_W'(RECOVER_TICKS) && !any_nonred;
  assign wrap       = phase_cnt == CNT_W'(FLASH_HALF - 1);
  assign viol = (inv_a || inv_b) ? FLT_INVALID :
                conflict ? FLT_CONFLICT :
                (ill_a || ill_b) ? FLT_SEQ :
                (stk_a || stk_b) ? FLT_NONRED :
                allred_cnt > CNT_W'(MAX_ALLRED) ? FLT_ALLRED : FLT_NONE;
  assign fault = state != MON;
  assign flash = state == FAULT;
  road_checker #(.MAX_NONRED(MAX_NONRED), .CNT_W(CNT_W)) u_road_a (
    .clk(clk), .rst(rst), .tick(tick), .en(in_mon), .clr(rec_done),
    .traffic(traffic_A), .invalid(inv_a), .illegal(ill_a), .stuck(stk_a)
  );
  road_checker #(.MAX_NONRED(MAX_NONRED), .CNT_W(CNT_W)) u_road_b (
    .clk(clk), .rst(rst), .tick(tick), .en(in_mon), .clr(rec_done),
    .traffic(traffic_B), .invalid(inv_b), .illegal(ill_b), .stuck(stk_b)
  );
  // next state, lamp drive, flash phase and dwell counters
  always_comb begin
    state_n      = state;
    lamp_a_n     = LIGHT_RED;
    lamp_b_n     = LIGHT_RED;
    code_n       = fault_code;
    phase_n      = phase;
    phase_cnt_n  = phase_cnt;
    rec_cnt_n    = rec_cnt;
    allred_cnt_n = allred_cnt;
    case (state)
      MON: begin
        allred_cnt_n = any_nonred ? '0 : (tick && allred_cnt != '1) ? allred_cnt + 1'b1 : allred_cnt;
        if (viol != FLT_NONE) begin
          state_n     = FAULT;
          code_n      = viol;
          phase_n     = 1'b1;
          phase_cnt_n = '0;
        end else begin
          lamp_a_n = traffic_A;
          lamp_b_n = traffic_B;
        end
      end
      FAULT: begin
        if (fault_clr) begin
          state_n     = RECOVER;
          phase_cnt_n = '0;
          rec_cnt_n   = '0;
        end else begin
          phase_n     = (tick && wrap) ? ~phase : phase;
          phase_cnt_n = !tick ? phase_cnt : wrap ? '0 : phase_cnt + 1'b1;
          lamp_a_n    = {phase_n, 2'b00};
          lamp_b_n    = {phase_n, 2'b00};
        end
      end
      RECOVER: begin
        rec_cnt_n = (tick && rec_cnt != CNT_W'(RECOVER_TICKS)) ? rec_cnt + 1'b1 : rec_cnt;
        if (rec_done) begin
          state_n      = MON;
          code_n       = FLT_NONE;
          allred_cnt_n = '0;
        end
      end
      default: state_n = MON;
    endcase
  end
  // state and output registers, asynchronously forced to the safe reset values
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= MON;
      lamp_A     <= LIGHT_RED;
      lamp_B     <= LIGHT_RED;
      fault_code <= FLT_NONE;
      phase      <= 1'b0;
      phase_cnt  <= '0;
      rec_cnt    <= '0;
      allred_cnt <= '0;
    end else begin
      state      <= state_n;
      lamp_A     <= lamp_a_n;
      lamp_B     <= lamp_b_n;
      fault_code <= code_n;
      phase      <= phase_n;
      phase_cnt  <= phase_cnt_n;
      rec_cnt    <= rec_cnt_n;
      allred_cnt <= allred_cnt_n;
    end
endmodule

// File: tb/tb_signal_monitor.sv
// tb_signal_monitor: directed and randomized checks against a behavioural monitor model
module tb_signal_monitor;
  import traffic_pkg::*;
  localparam logic [2:0] G = 3'b001, Y = 3'b010, R = 3'b100;
  logic clk = 0, rst = 1, tick = 0, fault_clr = 0;
  logic [2:0] traffic_A = R, traffic_B = R;
  logic [2:0] lamp_A, lamp_B, fault_code;
  logic fault, flash;
  int n_vec = 0, n_bad = 0;
  int m_code, m_flash_ticks, m_hold, m_allred;
  int m_nonred[2];
  bit m_recovering, m_lit;
  logic [2:0] m_prev[2], m_lamp[2];

  always #5 clk = ~clk;

  signal_monitor dut (
    .clk(clk), .rst(rst), .tick(tick), .traffic_A(traffic_A), .traffic_B(traffic_B),
    .fault_clr(fault_clr), .lamp_A(lamp_A), .lamp_B(lamp_B), .fault(fault),
    .fault_code(fault_code), .flash(flash)
  );

  function automatic logic [2:0] next_color(input logic [2:0] c);
    return c == G ? Y : c == Y ? R : c == R ? G : 3'b000;
  endfunction

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_code = 0; m_recovering = 0; m_lit = 0; m_flash_ticks = 0; m_hold = 0; m_allred = 0;
    m_nonred = '{0, 0}; m_prev = '{R, R}; m_lamp = '{R, R};
  endtask

  task automatic model_edge();
    logic [2:0] in[2];
    int code;
    in = '{traffic_A, traffic_B};
    if (m_code == 0) begin
      code = 0;
      if ($countones(in[0]) != 1 || $countones(in[1]) != 1) code = 1;
      else if (in[0] != R && in[1] != R) code = 2;
      else if ((in[0] != m_prev[0] && in[0] != next_color(m_prev[0])) ||
               (in[1] != m_prev[1] && in[1] != next_color(m_prev[1]))) code = 3;
      else if (m_nonred[0] > 12 || m_nonred[1] > 12) code = 4;
      else if (m_allred > 6) code = 5;
      for (int i = 0; i < 2; i++) begin
        m_nonred[i] = in[i] == R ? 0 : m_nonred[i] + int'(tick);
        m_prev[i] = in[i];
      end
      m_allred = (in[0] == R && in[1] == R) ? m_allred + int'(tick) : 0;
      if (code != 0) begin
        m_code = code; m_lit = 1; m_flash_ticks = 0; m_lamp = '{R, R};
      end else m_lamp = in;
    end else if (!m_recovering) begin
      if (fault_clr) begin
        m_recovering = 1; m_hold = 0; m_lamp = '{R, R};
      end else begin
        if (tick) begin
          m_flash_ticks++;
          if (m_flash_ticks == 1) begin m_lit = !m_lit; m_flash_ticks = 0; end
        end
        m_lamp = m_lit ? '{R, R} : '{3'b000, 3'b000};
      end
    end else begin
      if (m_hold >= 3 && in[0] == R && in[1] == R) begin
        m_code = 0; m_recovering = 0; m_allred = 0; m_nonred = '{0, 0}; m_prev = '{R, R};
      end else if (tick && m_hold < 3) m_hold++;
      m_lamp = '{R, R};
    end
  endtask

  task automatic check_all();
    chk("lamp_A", lamp_A, m_lamp[0]);
    chk("lamp_B", lamp_B, m_lamp[1]);
    chk("fault", {2'b00, fault}, {2'b00, m_code != 0});
    chk("fault_code", fault_code, 3'(m_code));
    chk("flash", {2'b00, flash}, {2'b00, m_code != 0 && !m_recovering});
  endtask

  task automatic cyc(input logic [2:0] a, input logic [2:0] b, input logic t, input logic c);
    traffic_A = a; traffic_B = b; tick = t; fault_clr = c;
    @(posedge clk);
    model_edge();
    #1 check_all();
  endtask

  task automatic hold_ticks(input logic [2:0] a, input logic [2:0] b, input int n);
    repeat (n) begin
      repeat ($urandom_range(0, 2)) cyc(a, b, 1'b0, 1'b0);
      cyc(a, b, 1'b1, 1'b0);
    end
  endtask

  task automatic recover();
    cyc(R, R, 1'b0, 1'b1);
    repeat (4) cyc(R, R, 1'b1, 1'b0);
    cyc(R, R, 1'b0, 1'b0);
    chk("recovered_fault", {2'b00, fault}, 3'd0);
  endtask

  initial begin
    logic [2:0] seq_a[6] = '{G, Y, R, R, R, R};
    logic [2:0] seq_b[6] = '{R, R, R, G, Y, R};
    int seq_n[6] = '{6, 2, 2, 6, 2, 2};
    logic [2:0] pick[6] = '{G, Y, R, R, 3'b011, 3'b000};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_lamp_A", lamp_A, R);
    chk("reset_lamp_B", lamp_B, R);
    chk("reset_fault", {2'b00, fault}, 3'd0);
    chk("reset_code", fault_code, 3'd0);
    chk("reset_flash", {2'b00, flash}, 3'd0);
    rst = 0;
    repeat (3) for (int i = 0; i < 6; i++) hold_ticks(seq_a[i], seq_b[i], seq_n[i]);
    chk("normal_code", fault_code, 3'd0);
    cyc(G, G, 1'b0, 1'b0);
    chk("conflict_code", fault_code, 3'd2);
    chk("conflict_lamp", lamp_A, R);
    chk("conflict_flash", {2'b00, flash}, 3'd1);
    repeat (3) cyc(R, R, 1'b0, 1'b0);
    cyc(R, R, 1'b1, 1'b0);
    chk("flash_off", lamp_A, 3'b000);
    repeat (5) begin
      repeat (3) cyc(R, R, 1'b0, 1'b0);
      cyc(R, R, 1'b1, 1'b0);
    end
    cyc(R, R, 1'b0, 1'b1);
    repeat (5) cyc(G, R, 1'b1, 1'b0);
    chk("recover_hold", {2'b00, fault}, 3'd1);
    chk("recover_lamp", lamp_A, R);
    cyc(R, R, 1'b0, 1'b0);
    chk("recover_exit", fault_code, 3'd0);
    repeat (2) cyc(G, R, 1'b0, 1'b0);
    cyc(R, R, 1'b0, 1'b0);
    chk("seq_code", fault_code, 3'd3);
    recover();
    cyc(G, R, 1'b0, 1'b0);
    cyc(R, 3'b011, 1'b0, 1'b0);
    chk("prio_code", fault_code, 3'd1);
    recover();
    repeat (13) cyc(G, R, 1'b1, 1'b0);
    chk("nonred_edge", {2'b00, fault}, 3'd0);
    cyc(G, R, 1'b0, 1'b0);
    chk("nonred_code", fault_code, 3'd4);
    recover();
    repeat (7) cyc(R, R, 1'b1, 1'b0);
    chk("allred_edge", {2'b00, fault}, 3'd0);
    cyc(R, R, 1'b0, 1'b0);
    chk("allred_code", fault_code, 3'd5);
    recover();
    cyc(G, G, 1'b0, 1'b0);
    #3 rst = 1;
    #1;
    model_reset();
    chk("async_lamp", lamp_B, R);
    chk("async_fault", {2'b00, fault}, 3'd0);
    chk("async_flash", {2'b00, flash}, 3'd0);
    chk("async_code", fault_code, 3'd0);
    #2 rst = 0;
    repeat (400) begin
      logic [2:0] a, b;
      a = $urandom_range(0, 1) ? R : pick[$urandom_range(0, 5)];
      b = $urandom_range(0, 1) ? R : pick[$urandom_range(0, 5)];
      cyc(a, b, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/signal_monitor.md
Name: signal_monitor

Overview:
- Conflict monitor and lamp driver placed directly downstream of the intersection light controller.
- Consumes the two 3-bit one-hot light codes for road A and road B: 001 green, 010 yellow, 100 red.
- Passes the codes to the lamp outputs with one cycle of registered latency.
- Checks code legality, cross-road conflict, per-road sequence order and dwell timeouts. On any violation it latches a fault and forces flashing red on both roads until cleared.

Parameters:
MAX_NONRED, 12, maximum ticks a road may remain non-red (green or yellow) before a stuck fault.
MAX_ALLRED, 6, maximum ticks both roads may remain red before a stuck fault.
FLASH_HALF, 1, ticks per on-phase and per off-phase of the failsafe red flash.
RECOVER_TICKS, 3, ticks of solid all-red hold after fault_clr.
CNT_W, 8, width of the internal dwell and phase counters.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
tick  in  1  one-cycle time-base strobe (1 s); all dwell timing counts ticks
traffic_A  in  3  controller code, road A
traffic_B  in  3  controller code, road B
fault_clr  in  1  level; requests exit from FAULT
lamp_A  out  3  registered lamp drive, road A
lamp_B  out  3  registered lamp drive, road B
fault  out  1  high while in FAULT or RECOVER
fault_code  out  3  first violation latched; 0 = none
flash  out  1  high in FAULT only

Behaviour:
- Reset values:
  - state MON.
  - lamp_A = lamp_B = 100.
  - fault = 0, fault_code = 0, flash = 0.
  - prev_A = prev_B = 100.
  - All counters 0.
- States: MON, FAULT, RECOVER.
- MON: each cycle, lamp_X <= traffic_X and prev_X <= traffic_X.
- Checks are evaluated combinationally in MON only. When more than one check fires in the same cycle, the lowest code wins. Codes:
  - 1 invalid: either input is not exactly one-hot.
  - 2 conflict: both inputs are non-red.
  - 3 illegal transition: traffic_X differs from prev_X and the step is not G->Y, Y->R or R->G (for example G->R or R->Y).
  - 4 non-red stuck: nonred_cnt_X > MAX_NONRED.
  - 5 all-red stuck: allred_cnt > MAX_ALLRED.
- Dwell counters:
  - nonred_cnt_X clears in any cycle where traffic_X is red, and increments on tick otherwise.
  - allred_cnt clears in any cycle where either road is non-red, and increments on tick otherwise.
  - All counters saturate at 2^CNT_W-1.
- Fault entry latency: detection in cycle N gives state = FAULT, fault = 1, flash = 1, fault_code = code and lamps = 100/100 at the N+1 register edge. The violating code never reaches the lamps.
- fault_code holds until rst or the RECOVER->MON transition.
- FAULT:
  - Lamp red bits follow phase and green/yellow bits are 0, so each lamp is 100 or 000.
  - phase = 1 on entry, with phase_cnt = 0.
  - Each tick increments phase_cnt. When phase_cnt reaches FLASH_HALF-1, phase toggles and phase_cnt clears.
  - Further violations are ignored and the first code is kept.
  - fault_clr = 1 at a clock edge gives RECOVER next cycle: lamps 100/100, flash = 0, phase_cnt = 0.
- RECOVER:
  - Lamps held at solid 100/100; fault stays 1; checks disabled.
  - Counts RECOVER_TICKS ticks.
  - After that, waits for a cycle in which traffic_A == traffic_B == 100, then moves to MON next cycle.
  - On that transition: fault = 0, fault_code = 0, prev_X = 100, all dwell counters cleared.
- fault_clr in MON or RECOVER is ignored.
- tick and a violation in the same cycle: the fault is taken, and the tick is not counted toward flash phase.
- rst asserted mid-FAULT or mid-RECOVER returns asynchronously to the reset values.

Decomposition:
- Shared package traffic_pkg holds:
  - Light code constants LIGHT_GREEN = 001, LIGHT_YELLOW = 010, LIGHT_RED = 100.
  - Fault code constants FLT_NONE=0, FLT_INVALID=1, FLT_CONFLICT=2, FLT_SEQ=3, FLT_NONRED=4, FLT_ALLRED=5.
  - Monitor state encoding.
- One natural sub-module, road_checker, instantiated twice. It holds prev_X and nonred_cnt_X and outputs invalid, illegal_transition and nonred_stuck flags.
- The conflict check, all-red counter, FSM and lamp drive stay at the top level.

Test Plan:
- Normal cycle: reset, then drive 001/100 for 6 ticks, 010/100 2, 100/100 2, 100/001 6, 100/010 2, 100/100 2, repeated 3 times -> lamps equal the inputs delayed 1 cycle; fault = 0, fault_code = 0 throughout.
- Conflict: in MON drive 001/001 for one cycle -> next cycle fault = 1, fault_code = 2, flash = 1, lamps = 100/100. Then with tick every 4 clocks, lamps alternate 100/000 every tick.
- Illegal step: 001/100 then 100/100 (G->R on A) -> fault_code = 3. Simultaneous invalid 011 on B in the same cycle -> fault_code = 1 (priority).
- Stuck: hold 001/100 for 13 ticks -> fault_code = 4 on the cycle after the 13th tick. Separately, 100/100 for 7 ticks -> fault_code = 5.
- Recovery: in FAULT, pulse fault_clr -> solid 100/100 for 3 ticks. Holding inputs at 001/100 keeps RECOVER. Driving 100/100 then gives MON next cycle with fault = 0, fault_code = 0.
- Async reset mid-FAULT: rst between clock edges -> immediate lamps 100/100, fault = 0, flash = 0, fault_code = 0.
